// File: rtl/and_result_checker.sv
// Scores basic_and (a, b, out) samples against a & b and latches the first mismatch; 1-cycle result latency.
// in_ready drops once NUM_VECTORS samples are taken or outside CHECK; the scoring stage never stalls.
module and_result_checker #(
    parameter int WIDTH       = 4,
    parameter int NUM_VECTORS = 5,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] pass_count,
    output logic [CNT_W-1:0] fail_count,
    output logic [CNT_W-1:0] first_fail_idx,
    output logic [WIDTH-1:0] first_fail_out,
    output logic [WIDTH-1:0] first_fail_a,
    output logic [WIDTH-1:0] first_fail_b
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] NUM_C    = CNT_W'(NUM_VECTORS);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_VECTORS - 1);

    state_t             state_q;
    logic [CNT_W-1:0]   accept_cnt_q;
    logic               s1_vld_q;
    logic [WIDTH-1:0]   s1_a_q;
    logic [WIDTH-1:0]   s1_b_q;
    logic [WIDTH-1:0]   s1_out_q;
    logic [CNT_W-1:0]   s1_idx_q;
    logic [CNT_W-1:0]   pass_cnt_q;
    logic [CNT_W-1:0]   fail_cnt_q;
    logic [CNT_W-1:0]   ff_idx_q;
    logic [WIDTH-1:0]   ff_a_q;
    logic [WIDTH-1:0]   ff_b_q;
    logic [WIDTH-1:0]   ff_out_q;

    logic               xfer;
    logic               s1_mismatch;
    logic [CNT_W-1:0]   accept_cnt_d;
    logic [CNT_W-1:0]   pass_cnt_d;
    logic [CNT_W-1:0]   fail_cnt_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    assign in_ready    = (state_q == CHECK) && (accept_cnt_q < NUM_C);
    assign xfer        = in_valid && in_ready;
    assign s1_mismatch = s1_out_q != (s1_a_q & s1_b_q);

    always_comb begin
        accept_cnt_d = sat_inc(accept_cnt_q);
        pass_cnt_d   = sat_inc(pass_cnt_q);
        fail_cnt_d   = sat_inc(fail_cnt_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            accept_cnt_q <= '0;
            s1_vld_q     <= 1'b0;
            s1_a_q       <= '0;
            s1_b_q       <= '0;
            s1_out_q     <= '0;
            s1_idx_q     <= '0;
            pass_cnt_q   <= '0;
            fail_cnt_q   <= '0;
            ff_idx_q     <= '0;
            ff_a_q       <= '0;
            ff_b_q       <= '0;
            ff_out_q     <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    // A new run wipes every result; a sample offered alongside start is dropped.
                    if (start) begin
                        state_q      <= CHECK;
                        accept_cnt_q <= '0;
                        s1_vld_q     <= 1'b0;
                        pass_cnt_q   <= '0;
                        fail_cnt_q   <= '0;
                        ff_idx_q     <= '0;
                        ff_a_q       <= '0;
                        ff_b_q       <= '0;
                        ff_out_q     <= '0;
                    end
                end
                CHECK: begin
                    s1_vld_q <= xfer;
                    if (xfer) begin
                        s1_a_q       <= in_a;
                        s1_b_q       <= in_b;
                        s1_out_q     <= in_out;
                        s1_idx_q     <= accept_cnt_q;
                        accept_cnt_q <= accept_cnt_d;
                    end
                    if (s1_vld_q) begin
                        if (s1_mismatch) begin
                            fail_cnt_q <= fail_cnt_d;
                            if (fail_cnt_q == '0) begin
                                ff_idx_q <= s1_idx_q;
                                ff_a_q   <= s1_a_q;
                                ff_b_q   <= s1_b_q;
                                ff_out_q <= s1_out_q;
                            end
                        end else begin
                            pass_cnt_q <= pass_cnt_d;
                        end
                        if (s1_idx_q == LAST_IDX) begin
                            state_q <= DONE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy           = (state_q == CHECK);
    assign done           = (state_q == DONE);
    assign pass           = done && (fail_cnt_q == '0);
    assign pass_count     = pass_cnt_q;
    assign fail_count     = fail_cnt_q;
    assign first_fail_idx = ff_idx_q;
    assign first_fail_a   = ff_a_q;
    assign first_fail_b   = ff_b_q;
    assign first_fail_out = ff_out_q;

endmodule

// File: tb/tb_and_result_checker.sv
// Directed bench for and_result_checker: hand-computed vectors, counts and first-fail capture.
module tb_and_result_checker;

    localparam int WIDTH = 4;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [WIDTH-1:0] in_out;
    logic             busy;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] pass_count;
    logic [CNT_W-1:0] fail_count;
    logic [CNT_W-1:0] first_fail_idx;
    logic [WIDTH-1:0] first_fail_out;
    logic [WIDTH-1:0] first_fail_a;
    logic [WIDTH-1:0] first_fail_b;

    int checks   = 0;
    int failures = 0;

    logic [3:0] good_a   [5] = '{4'b0000, 4'b1111, 4'b1100, 4'b1100, 4'b1100};
    logic [3:0] good_b   [5] = '{4'b0000, 4'b0101, 4'b1111, 4'b0011, 4'b1010};
    logic [3:0] good_out [5] = '{4'b0000, 4'b0101, 4'b1100, 4'b0000, 4'b1000};
    logic [3:0] bad_out  [5] = '{4'b0000, 4'b0101, 4'b1101, 4'b0000, 4'b0000};

    and_result_checker #(.WIDTH(WIDTH), .NUM_VECTORS(5), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_out(in_out),
        .busy(busy), .done(done), .pass(pass),
        .pass_count(pass_count), .fail_count(fail_count),
        .first_fail_idx(first_fail_idx), .first_fail_out(first_fail_out),
        .first_fail_a(first_fail_a), .first_fail_b(first_fail_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [3:0] o);
        int n;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        in_out = o;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (n == 50) chk("send_timeout", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 50) begin
            tick();
            n++;
        end
        if (n == 50) chk("done_timeout", 32'(done), 32'd1);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0;
        in_a = '0; in_b = '0; in_out = '0;
        tick();
        tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pass", 32'(pass), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd0);
        chk("rst_pcnt", 32'(pass_count), 32'd0);
        chk("rst_fcnt", 32'(fail_count), 32'd0);
        rst = 1'b0;
        tick();

        // Good run, back-to-back
        pulse_start();
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 5; i++) send(good_a[i], good_b[i], good_out[i]);
        chk("good_done_lat0", 32'(done), 32'd0);
        chk("good_ready_off", 32'(in_ready), 32'd0);
        tick();
        chk("good_done_lat1", 32'(done), 32'd1);
        chk("good_pass", 32'(pass), 32'd1);
        chk("good_pcnt", 32'(pass_count), 32'd5);
        chk("good_fcnt", 32'(fail_count), 32'd0);
        chk("good_busy", 32'(busy), 32'd0);

        // Fault run, with an ignored start in the middle
        pulse_start();
        chk("restart_busy", 32'(busy), 32'd1);
        chk("restart_pcnt", 32'(pass_count), 32'd0);
        send(good_a[0], good_b[0], bad_out[0]);
        send(good_a[1], good_b[1], bad_out[1]);
        tick();
        pulse_start();
        chk("midstart_busy", 32'(busy), 32'd1);
        chk("midstart_pcnt", 32'(pass_count), 32'd2);
        for (int i = 2; i < 5; i++) send(good_a[i], good_b[i], bad_out[i]);
        wait_done();
        chk("fault_fcnt", 32'(fail_count), 32'd2);
        chk("fault_pcnt", 32'(pass_count), 32'd3);
        chk("fault_pass", 32'(pass), 32'd0);
        chk("fault_idx", 32'(first_fail_idx), 32'd2);
        chk("fault_a", 32'(first_fail_a), 32'hC);
        chk("fault_b", 32'(first_fail_b), 32'hF);
        chk("fault_out", 32'(first_fail_out), 32'hD);

        // start and a valid sample together in DONE: start wins, sample dropped
        in_valid = 1'b1; in_a = 4'hF; in_b = 4'hF; in_out = 4'h0;
        pulse_start();
        in_valid = 1'b0;
        tick();
        tick();
        chk("dstart_busy", 32'(busy), 32'd1);
        chk("dstart_fcnt", 32'(fail_count), 32'd0);
        chk("dstart_pcnt", 32'(pass_count), 32'd0);
        chk("dstart_ffout", 32'(first_fail_out), 32'd0);

        // Gapped valid, then valid held with no room left
        for (int i = 0; i < 5; i++) begin
            send(good_a[i], good_b[i], good_out[i]);
            repeat (3) tick();
        end
        in_valid = 1'b1; in_a = 4'h3; in_b = 4'h3; in_out = 4'h0;
        repeat (4) tick();
        chk("gap_ready", 32'(in_ready), 32'd0);
        chk("gap_done", 32'(done), 32'd1);
        chk("gap_pcnt", 32'(pass_count), 32'd5);
        chk("gap_fcnt", 32'(fail_count), 32'd0);
        in_valid = 1'b0;

        // Reset mid-run, then a fresh good run
        pulse_start();
        send(good_a[0], good_b[0], good_out[0]);
        send(good_a[1], good_b[1], 4'hF);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_pcnt", 32'(pass_count), 32'd0);
        chk("mrst_fcnt", 32'(fail_count), 32'd0);
        chk("mrst_ready", 32'(in_ready), 32'd0);
        pulse_start();
        for (int i = 0; i < 5; i++) send(good_a[i], good_b[i], good_out[i]);
        wait_done();
        chk("fresh_pass", 32'(pass), 32'd1);
        chk("fresh_pcnt", 32'(pass_count), 32'd5);
        chk("fresh_fcnt", 32'(fail_count), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
